// File: rtl/mem_rsp_controller.sv
// mem_rsp_controller
//   Single-outstanding memory request controller. Accepts one load/store from
//   the LSU, issues it on a valid/ready memory request channel, waits for the
//   single-cycle memory response and delivers the result as a one-cycle pulse
//   to the downstream response skid buffer. A bounded wait timer turns a
//   stalled memory into an error response; the late response that eventually
//   arrives for the abandoned request is then dropped.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   lsu_req_*             LSU request (vld/rdy handshake, we, addr, wdata)
//   mem_req_*             memory request channel (vld/rdy, registered fields)
//   mem_rsp_vld/_data     memory response, single-cycle pulse
//   rsp_rdy               skid buffer has room
//   m_rsp_vld/_data/_err  response pulse; data/err are 0 when vld is 0
module mem_rsp_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_req_vld,
    output logic                  lsu_req_rdy,
    input  logic                  lsu_req_we,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    output logic                  mem_req_vld,
    input  logic                  mem_req_rdy,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  rsp_rdy,
    output logic                  m_rsp_vld,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  m_rsp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // A zero-width timer is not legal, so keep one bit when the timeout is off.
    localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            T_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]            state_q,    state_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [TW-1:0]         timer_q,    timer_d;
    logic                  stale_q,    stale_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timer_d    = timer_q;
        stale_d    = stale_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        // Any response pulse while stale is set belongs to an abandoned
        // request; it consumes the stale flag wherever it arrives.
        if (mem_rsp_vld) begin
            stale_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (lsu_req_vld) begin
                    we_d    = lsu_req_we;
                    addr_d  = lsu_req_addr;
                    wdata_d = lsu_req_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_rdy) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A fresh response beats a timeout landing in the same cycle;
                // a dropped stale response does not, so the timeout still fires.
                if (mem_rsp_vld && !stale_q) begin
                    rsp_data_d = we_q ? '0 : mem_rsp_data;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (T_EN && (timer_q == T_LAST)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    stale_d    = 1'b1;
                    state_d    = S_RESP;
                end
            end
            default: begin
                if (rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            timer_q    <= '0;
            stale_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            timer_q    <= timer_d;
            stale_q    <= stale_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign lsu_req_rdy   = (state_q == S_IDLE);
    assign mem_req_vld   = (state_q == S_ISSUE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

    // The pulse is gated by rsp_rdy directly so it fires the cycle room appears.
    assign m_rsp_vld  = (state_q == S_RESP) && rsp_rdy;
    assign m_rsp_data = m_rsp_vld ? rsp_data_q : '0;
    assign m_rsp_err  = m_rsp_vld ? rsp_err_q  : 1'b0;

endmodule

// File: tb/tb_mem_rsp_controller.sv
// Directed and randomized bench for mem_rsp_controller (TIMEOUT = 4).
// Expected responses come from a transaction-level model: a stale flag plus
// the rule "first non-stale response within TIMEOUT wait cycles, else error".
module tb_mem_rsp_controller;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          lsu_req_vld;
    logic          lsu_req_rdy;
    logic          lsu_req_we;
    logic [AW-1:0] lsu_req_addr;
    logic [DW-1:0] lsu_req_wdata;
    logic          mem_req_vld;
    logic          mem_req_rdy;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_vld;
    logic [DW-1:0] mem_rsp_data;
    logic          rsp_rdy;
    logic          m_rsp_vld;
    logic [DW-1:0] m_rsp_data;
    logic          m_rsp_err;

    mem_rsp_controller #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lsu_req_vld  (lsu_req_vld),
        .lsu_req_rdy  (lsu_req_rdy),
        .lsu_req_we   (lsu_req_we),
        .lsu_req_addr (lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_we   (mem_req_we),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data),
        .rsp_rdy      (rsp_rdy),
        .m_rsp_vld    (m_rsp_vld),
        .m_rsp_data   (m_rsp_data),
        .m_rsp_err    (m_rsp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    bit            m_stale = 1'b0;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled after negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        #1;
        chk("idle_lsu_rdy", lsu_req_rdy, 1);
        chk("idle_mem_vld", mem_req_vld, 0);
        cur_we        = we;
        cur_addr      = addr;
        cur_wdata     = wdata;
        lsu_req_vld   = 1'b1;
        lsu_req_we    = we;
        lsu_req_addr  = addr;
        lsu_req_wdata = wdata;
        tick();
        lsu_req_vld   = 1'b0;
        lsu_req_we    = ~we;
        lsu_req_addr  = AW'($urandom);
        lsu_req_wdata = DW'($urandom);
    endtask

    // Memory holds off the request for 'stall' cycles before accepting.
    task automatic issue(input int stall);
        for (int s = 0; s <= stall; s++) begin
            mem_req_rdy = (s == stall);
            #1;
            chk("issue_vld",   mem_req_vld,   1);
            chk("issue_we",    mem_req_we,    cur_we);
            chk("issue_addr",  mem_req_addr,  cur_addr);
            chk("issue_wdata", mem_req_wdata, cur_wdata);
            chk("issue_lsu_rdy", lsu_req_rdy, 0);
            tick();
        end
        mem_req_rdy = 1'b0;
    endtask

    // Drives response pulses at wait-cycle indices late_at / rsp_at (-1 = none)
    // and derives the expected delivered response from the model.
    task automatic wait_phase(input int late_at, input int rsp_at, input logic [DW-1:0] rdata,
                              output logic exp_err, output logic [DW-1:0] exp_data);
        bit done = 1'b0;
        exp_err  = 1'b0;
        exp_data = '0;
        for (int i = 0; i < 2 * TO && !done; i++) begin
            mem_rsp_vld  = (i == late_at) || (i == rsp_at);
            mem_rsp_data = (i == rsp_at) ? rdata : DW'($urandom);
            #1;
            chk("wait_m_vld",   m_rsp_vld,   0);
            chk("wait_mem_vld", mem_req_vld, 0);
            chk("wait_lsu_rdy", lsu_req_rdy, 0);
            if (mem_rsp_vld && !m_stale) begin
                exp_err  = 1'b0;
                exp_data = cur_we ? '0 : mem_rsp_data;
                done     = 1'b1;
            end else begin
                if (mem_rsp_vld) m_stale = 1'b0;
                if (i == TO - 1) begin
                    exp_err  = 1'b1;
                    exp_data = '0;
                    m_stale  = 1'b1;
                    done     = 1'b1;
                end
            end
            tick();
        end
        mem_rsp_vld = 1'b0;
        chk("wait_resolved", done, 1);
    endtask

    task automatic resp_phase(input int stall, input logic exp_err, input logic [DW-1:0] exp_data);
        for (int s = 0; s < stall; s++) begin
            rsp_rdy = 1'b0;
            #1;
            chk("hold_m_vld",   m_rsp_vld,   0);
            chk("hold_m_data",  m_rsp_data,  0);
            chk("hold_m_err",   m_rsp_err,   0);
            chk("hold_lsu_rdy", lsu_req_rdy, 0);
            tick();
        end
        rsp_rdy = 1'b1;
        #1;
        chk("rsp_vld",  m_rsp_vld,  1);
        chk("rsp_data", m_rsp_data, exp_data);
        chk("rsp_err",  m_rsp_err,  exp_err);
        tick();
        #1;
        chk("post_m_vld",   m_rsp_vld,   0);
        chk("post_lsu_rdy", lsu_req_rdy, 1);
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int req_stall, input int late_at, input int rsp_at,
                       input logic [DW-1:0] rdata, input int rsp_stall);
        logic          e_err;
        logic [DW-1:0] e_data;
        start_req(we, addr, wdata);
        issue(req_stall);
        wait_phase(late_at, rsp_at, rdata, e_err, e_data);
        resp_phase(rsp_stall, e_err, e_data);
    endtask

    initial begin
        reset         = 1'b1;
        lsu_req_vld   = 1'b0;
        lsu_req_we    = 1'b0;
        lsu_req_addr  = '0;
        lsu_req_wdata = '0;
        mem_req_rdy   = 1'b0;
        mem_rsp_vld   = 1'b0;
        mem_rsp_data  = '0;
        rsp_rdy       = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_lsu_rdy",   lsu_req_rdy,   1);
        chk("rst_mem_vld",   mem_req_vld,   0);
        chk("rst_mem_we",    mem_req_we,    0);
        chk("rst_mem_addr",  mem_req_addr,  0);
        chk("rst_mem_wdata", mem_req_wdata, 0);
        chk("rst_m_vld",     m_rsp_vld,     0);
        chk("rst_m_data",    m_rsp_data,    0);
        chk("rst_m_err",     m_rsp_err,     0);

        // Load, memory ready, response one cycle after issue
        txn(1'b0, 8'h10, 8'h00, 0, -1, 0, 8'hA5, 0);
        // Store with 3 cycles of request backpressure; store returns 0
        txn(1'b1, 8'h20, 8'h3C, 3, -1, 0, 8'hE7, 0);
        // Skid buffer full for 5 cycles
        txn(1'b0, 8'h31, 8'h00, 0, -1, 1, 8'h5A, 5);
        // Timeout, then the late response is dropped during the next WAIT
        txn(1'b0, 8'h40, 8'h00, 0, -1, -1, 8'h00, 0);
        txn(1'b0, 8'h41, 8'h00, 0, 1, 2, 8'h77, 0);
        // Response on the final wait cycle wins; stale stays clear, so the
        // next immediate response must be delivered
        txn(1'b0, 8'h50, 8'h00, 1, -1, TO - 1, 8'hC3, 0);
        txn(1'b0, 8'h51, 8'h00, 0, -1, 0, 8'h99, 0);

        // Reset in the middle of WAIT: no response is produced
        start_req(1'b0, 8'h60, 8'h00);
        issue(0);
        tick();
        reset = 1'b1;
        #1;
        chk("rstw_m_vld", m_rsp_vld, 0);
        tick();
        reset   = 1'b0;
        m_stale = 1'b0;
        #1;
        chk("rstw_lsu_rdy", lsu_req_rdy, 1);
        chk("rstw_mem_vld", mem_req_vld, 0);
        chk("rstw_m_vld",   m_rsp_vld,   0);
        tick();
        #1;
        chk("rstw_m_vld2", m_rsp_vld, 0);

        // Randomized transactions against the model
        for (int n = 0; n < 30; n++) begin
            int late_at;
            int rsp_at;
            late_at = -1;
            rsp_at  = int'($urandom_range(0, TO + 1));
            if (m_stale && ($urandom_range(0, 1) == 1)) begin
                if ($urandom_range(0, 1) == 1) begin
                    // Late response arrives while idle and clears stale
                    mem_rsp_vld  = 1'b1;
                    mem_rsp_data = DW'($urandom);
                    #1;
                    chk("idle_pulse_m_vld", m_rsp_vld, 0);
                    tick();
                    mem_rsp_vld = 1'b0;
                    m_stale     = 1'b0;
                end else begin
                    late_at = int'($urandom_range(0, 2));
                    rsp_at  = late_at + 1 + int'($urandom_range(0, 3));
                end
            end
            txn(logic'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, 3)), late_at, rsp_at, DW'($urandom),
                int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
